cpu_debug_loader: RTL and testbench
===================================

Name: cpu_debug_loader

Overview:
Host-side debug and load controller for the 8-bit two-register multi-cycle `cpu`. It takes a byte command stream over valid/ready and performs three jobs:
- writes program and data bytes into the CPU's 256x8 memory;
- releases the CPU from reset and waits for `halted`, with a cycle timeout;
- streams memory contents back over a valid/ready response channel.

It is the in-hardware counterpart of backdoor load/run/check. It owns the memory port only while it holds the CPU in reset; the top level muxes the memory port on `cpu_reset`.

Parameters:
- ADDR_W, 8, memory address width (256 bytes)
- DATA_W, 8, memory and stream byte width
- TMO_W, 16, width of the run timeout and of the cycle counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command byte valid
- cmd_ready  out  1  command byte accepted when valid&ready
- cmd_data  in  8  command byte
- rsp_valid  out  1  response byte valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  8  response byte
- mem_we  out  1  memory write strobe
- mem_addr  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid one cycle after mem_addr (synchronous read)
- cpu_reset  out  1  held-reset to the CPU; high except during RUN
- cpu_halted  in  1  CPU halted flag
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0. State=IDLE and all counters are 0.
- Reset mid-operation: the next cycle is IDLE. No further mem_we. cpu_reset=1. A pending rsp byte is dropped.
- cmd_ready is high only in states that consume a byte: IDLE, W_ADDR, W_CNT, W_DATA, R_ADDR, R_CNT, T_HI, T_LO.
- WRITE command, opcode 0x01, bytes `addr, cnt, data × N`:
  - N = cnt, with cnt=0 meaning 256.
  - Each accepted data byte drives mem_we=1 for exactly one cycle, the cycle after acceptance, with mem_addr and mem_wdata registered.
  - The address post-increments and wraps 255→0.
  - No response. Returns to IDLE after the Nth write strobe.
- READ command, opcode 0x02, bytes `addr, cnt`:
  - Per byte: R_ISSUE drives mem_addr. R_WAIT captures mem_rdata on the next cycle. R_SEND holds rsp_valid=1 with rsp_data stable until rsp_ready.
  - Then the address increments (wraps 255→0) and the next byte starts.
  - N = cnt, with cnt=0 meaning 256.
- RUN command, opcode 0x03, bytes `tmo_hi, tmo_lo`:
  - T = {hi,lo}.
  - T=0: no CPU release; the response is immediate with status 0x01 and count 0.
  - Otherwise, cpu_reset falls the cycle after tmo_lo is accepted. The cycle counter increments on every clk with cpu_reset=0.
  - cpu_halted=1 sampled: status 0x00. If halt and count==T occur in the same cycle, halt wins.
  - Else count==T: status 0x01.
  - In both cases cpu_reset rises on the next cycle. Memory contents persist; CPU registers are reset.
- RUN response: 3 bytes in order — status, count[15:8], count[7:0] — each under full valid/ready.
- Unknown opcode: response is a single 0xFF, then IDLE.
- Response ordering: the stream is strictly in command order, and no new command is accepted until the current response has completely drained.
- Width rules:
  - address arithmetic is mod 256;
  - the N counter is 9 bits;
  - the cycle counter saturates at T and never wraps.

Decomposition:
- Package `dbg_pkg` holds:
  - opcode constants: OP_WRITE=0x01, OP_READ=0x02, OP_RUN=0x03;
  - status constants: ST_OK=0x00, ST_TMO=0x01, ST_BADOP=0xFF;
  - state enum `dbg_state_t` with IDLE, W_ADDR, W_CNT, W_DATA, W_STROBE, R_ADDR, R_CNT, R_ISSUE, R_WAIT, R_SEND, T_HI, T_LO, RUN, RSP0, RSP1, RSP2, ERR.
- One sub-module, `dbg_rsp_reg`: a one-entry valid/ready output register holding rsp_data stable under backpressure.

Test Plan:
- WRITE addr 0, 11 bytes `35 3F 14 68 81 F0 20 3F 44 74 F0`; WRITE mem[12]=0x0C; RUN T=200 → status 0x00 with count<200. READ addr 19 cnt 1 → 0x05. CPU r0=5, r1=19.
- WRITE mem[0]=0x9F (jmp −1, infinite loop); RUN T=50 → response `01 00 32`. cpu_reset=1 on the cycle after count reaches 50.
- WRITE addr 255 cnt 2 data `AA 55` → mem[255]=0xAA, mem[0]=0x55. READ addr 255 cnt 2 → `AA 55`.
- READ with rsp_ready low for 5 cycles → rsp_valid stays 1 and rsp_data is unchanged. cmd_ready=0 throughout.
- Opcode 0x7E → single response 0xFF. A following RUN T=0 → `01 00 00` with cpu_reset never falling.
- reset asserted after the 2nd data byte of a WRITE cnt=4 → exactly 2 mem_we pulses total. busy=0 and cpu_reset=1 the next cycle.

Source files
------------

// File: rtl/cpu_debug_loader_pkg.sv
// Shared constants, state encoding and helpers for the CPU debug/load controller.
package dbg_pkg;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;
   localparam logic [7:0] OP_RUN   = 8'h03;

   localparam logic [7:0] ST_OK    = 8'h00;
   localparam logic [7:0] ST_TMO   = 8'h01;
   localparam logic [7:0] ST_BADOP = 8'hFF;

   typedef enum logic [4:0] {
      IDLE,
      W_ADDR,
      W_CNT,
      W_DATA,
      W_STROBE,
      R_ADDR,
      R_CNT,
      R_ISSUE,
      R_WAIT,
      R_SEND,
      T_HI,
      T_LO,
      RUN,
      RSP0,
      RSP1,
      RSP2,
      ERR
   } dbg_state_t;

   // States that take a byte from the command stream
   function automatic logic consumes_byte(input dbg_state_t s);
      case (s)
         IDLE, W_ADDR, W_CNT, W_DATA, R_ADDR, R_CNT, T_HI, T_LO: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_debug_loader_if.sv
// Bundle of command/response streams, memory port and CPU control seen by the loader.
// master = host/system side, slave = the loader itself.
interface cpu_debug_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              cpu_reset;
   logic              cpu_halted;
   logic              busy;

   modport master (
      output cmd_valid, cmd_data, rsp_ready, mem_rdata, cpu_halted,
      input  cmd_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata, cpu_reset, busy
   );

   modport slave (
      input  cmd_valid, cmd_data, rsp_ready, mem_rdata, cpu_halted,
      output cmd_ready, rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata, cpu_reset, busy
   );
endinterface

// File: rtl/cpu_debug_loader_rsp_reg.sv
// One-entry output register for the response stream; data is held stable
// while the consumer applies backpressure. A load wins over a drain so the
// FSM can queue the next byte in the same cycle the current one is taken.
module dbg_rsp_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              rsp_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data
);

   // Hold the pending byte until it is accepted; reset drops it
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else if (load) begin
         rsp_valid <= 1'b1;
         rsp_data  <= load_data;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/cpu_debug_loader.sv
// Host-side debug/load controller: writes CPU memory, runs the CPU with a
// cycle timeout and streams memory back, all driven by a byte command stream.
// The memory port is only meaningful while cpu_reset is high.
module cpu_debug_loader
   import dbg_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int TMO_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   cpu_debug_loader_if.slave  bus
);

   dbg_state_t        state;
   dbg_state_t        state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_load;
   logic [TMO_W-1:0]  tmo;
   logic [TMO_W-1:0]  tmo_full;
   logic [TMO_W-1:0]  cyc;
   logic [TMO_W-1:0]  cyc_inc;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              cpu_reset_q;
   logic              cmd_ready_q;
   logic              busy_q;
   logic              cmd_fire;
   logic              rsp_fire;
   logic              last_byte;
   logic              halt_now;
   logic              tmo_now;
   logic              rsp_load;
   logic [DATA_W-1:0] rsp_load_data;

   assign cmd_fire  = bus.cmd_valid && cmd_ready_q;
   assign rsp_fire  = bus.rsp_valid && bus.rsp_ready;
   assign last_byte = (cnt == {{ADDR_W{1'b0}}, 1'b1});
   assign cnt_load  = (bus.cmd_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, bus.cmd_data};
   assign tmo_full  = {tmo[TMO_W-1:DATA_W], bus.cmd_data};
   assign cyc_inc   = cyc + 1'b1;
   assign halt_now  = bus.cpu_halted;
   assign tmo_now   = (cyc_inc == tmo);

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_reset = cpu_reset_q;
   assign bus.busy      = busy_q;

   // Next-state decode of the command/response sequencer
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cmd_fire) begin
               case (bus.cmd_data)
                  OP_WRITE: state_nxt = W_ADDR;
                  OP_READ:  state_nxt = R_ADDR;
                  OP_RUN:   state_nxt = T_HI;
                  default:  state_nxt = ERR;
               endcase
            end
         end
         W_ADDR:   if (cmd_fire) state_nxt = W_CNT;
         W_CNT:    if (cmd_fire) state_nxt = W_DATA;
         W_DATA:   if (cmd_fire) state_nxt = W_STROBE;
         W_STROBE: state_nxt = last_byte ? IDLE : W_DATA;
         R_ADDR:   if (cmd_fire) state_nxt = R_CNT;
         R_CNT:    if (cmd_fire) state_nxt = R_ISSUE;
         R_ISSUE:  state_nxt = R_WAIT;
         R_WAIT:   state_nxt = R_SEND;
         R_SEND:   if (rsp_fire) state_nxt = last_byte ? IDLE : R_ISSUE;
         T_HI:     if (cmd_fire) state_nxt = T_LO;
         T_LO:     if (cmd_fire) state_nxt = (tmo_full == '0) ? RSP0 : RUN;
         RUN:      if (halt_now || tmo_now) state_nxt = RSP0;
         RSP0:     if (rsp_fire) state_nxt = RSP1;
         RSP1:     if (rsp_fire) state_nxt = RSP2;
         RSP2:     if (rsp_fire) state_nxt = IDLE;
         ERR:      if (rsp_fire) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Decide which byte, if any, is pushed into the response register this cycle
   always_comb begin
      rsp_load      = 1'b0;
      rsp_load_data = '0;
      case (state)
         IDLE: begin
            if (cmd_fire && (bus.cmd_data != OP_WRITE) && (bus.cmd_data != OP_READ) &&
                (bus.cmd_data != OP_RUN)) begin
               rsp_load      = 1'b1;
               rsp_load_data = ST_BADOP;
            end
         end
         R_WAIT: begin
            rsp_load      = 1'b1;
            rsp_load_data = bus.mem_rdata;
         end
         T_LO: begin
            if (cmd_fire && (tmo_full == '0)) begin
               rsp_load      = 1'b1;
               rsp_load_data = ST_TMO;
            end
         end
         RUN: begin
            if (halt_now) begin
               rsp_load      = 1'b1;
               rsp_load_data = ST_OK;
            end else if (tmo_now) begin
               rsp_load      = 1'b1;
               rsp_load_data = ST_TMO;
            end
         end
         RSP0: begin
            if (rsp_fire) begin
               rsp_load      = 1'b1;
               rsp_load_data = cyc[TMO_W-1:DATA_W];
            end
         end
         RSP1: begin
            if (rsp_fire) begin
               rsp_load      = 1'b1;
               rsp_load_data = cyc[DATA_W-1:0];
            end
         end
         default: begin
            rsp_load      = 1'b0;
            rsp_load_data = '0;
         end
      endcase
   end

   // State register, registered handshake/status outputs and the datapath counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         addr        <= '0;
         cnt         <= '0;
         tmo         <= '0;
         cyc         <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         cpu_reset_q <= 1'b1;
      end else begin
         state       <= state_nxt;
         cmd_ready_q <= consumes_byte(state_nxt);
         busy_q      <= (state_nxt != IDLE);
         we_q        <= 1'b0;
         case (state)
            W_ADDR, R_ADDR: if (cmd_fire) addr <= bus.cmd_data;
            W_CNT, R_CNT:   if (cmd_fire) cnt <= cnt_load;
            W_DATA: begin
               if (cmd_fire) begin
                  we_q    <= 1'b1;
                  wdata_q <= bus.cmd_data;
               end
            end
            W_STROBE: begin
               addr <= addr + 1'b1;
               cnt  <= cnt - 1'b1;
            end
            R_SEND: begin
               if (rsp_fire) begin
                  addr <= addr + 1'b1;
                  cnt  <= cnt - 1'b1;
               end
            end
            T_HI: if (cmd_fire) tmo[TMO_W-1:DATA_W] <= bus.cmd_data;
            T_LO: begin
               if (cmd_fire) begin
                  tmo[DATA_W-1:0] <= bus.cmd_data;
                  cyc             <= '0;
                  if (tmo_full != '0) cpu_reset_q <= 1'b0;
               end
            end
            RUN: begin
               cyc <= cyc_inc;
               if (halt_now || tmo_now) cpu_reset_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   dbg_rsp_reg #(
      .DATA_W (DATA_W)
   ) u_rsp (
      .clk       (clk),
      .reset     (reset),
      .load      (rsp_load),
      .load_data (rsp_load_data),
      .rsp_ready (bus.rsp_ready),
      .rsp_valid (bus.rsp_valid),
      .rsp_data  (bus.rsp_data)
   );

endmodule

// File: tb/tb_cpu_debug_loader.sv
// Testbench for cpu_debug_loader: a table of command/response vectors plus
// hand-written sequences for backpressure, mid-write reset and a 256-byte read.
// The CPU is modelled as "halts after halt_at released cycles"; memory is a
// 256x8 synchronous-read array owned by the bench.
module tb_cpu_debug_loader;

   localparam int NEVER = 32'h7FFF_FFFF;

   typedef struct {
      string        name;
      int           ncmd;
      logic [127:0] cmd;
      int           nrsp;
      logic [31:0]  rsp;
      int           halt_at;
      int           exp_we;
      int           exp_low;
   } vec_t;

   logic clk;
   logic reset;
   cpu_debug_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   cpu_debug_loader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [256];
   int         run_cyc;
   int         halt_at;
   int         we_cnt;
   int         low_cnt;
   logic [7:0] rsp_q [$];
   vec_t       vecs [$];
   int         checks;
   int         failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory written by the loader's strobes
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   // CPU model: counts released cycles and halts once halt_at have elapsed
   always @(posedge clk) begin
      if (bus.cpu_reset) run_cyc <= 0;
      else               run_cyc <= run_cyc + 1;
   end

   assign bus.cpu_halted = !bus.cpu_reset && (run_cyc >= halt_at);

   // Observe handshakes, write strobes and released cycles away from the clock edge
   always @(negedge clk) begin
      if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_data);
      if (bus.mem_we) we_cnt <= we_cnt + 1;
      if (!bus.cpu_reset) low_cnt <= low_cnt + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      int   guard;
      logic ok;
      guard         = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = b;
      do begin
         @(negedge clk);
         ok = bus.cmd_ready;
         guard++;
      end while (!ok && guard < 500);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL cmd_accept_timeout byte %0h: cmd_ready got 0 expected 1", b);
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((bus.busy || bus.rsp_valid) && n < limit);
      checks++;
      if (bus.busy || bus.rsp_valid) begin
         failures++;
         $display("[TB] FAIL %s idle_timeout: busy got %0b expected 0", name, bus.busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input string name, input int ncmd, input logic [127:0] cmd,
                         input int nrsp, input logic [31:0] rsp, input int h,
                         input int exp_we, input int exp_low);
      vec_t v;
      v.name    = name;
      v.ncmd    = ncmd;
      v.cmd     = cmd;
      v.nrsp    = nrsp;
      v.rsp     = rsp;
      v.halt_at = h;
      v.exp_we  = exp_we;
      v.exp_low = exp_low;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      int         we_base;
      int         low_base;
      logic [7:0] got;
      halt_at  = v.halt_at;
      we_base  = we_cnt;
      low_base = low_cnt;
      rsp_q.delete();
      for (int i = 0; i < v.ncmd; i++) sendByte(v.cmd[(v.ncmd-1-i)*8 +: 8]);
      waitIdle(v.name, 2000);
      checkOutput($sformatf("%s rsp_count", v.name), rsp_q.size(), v.nrsp);
      for (int j = 0; j < v.nrsp; j++) begin
         got = (j < rsp_q.size()) ? rsp_q[j] : 8'hXX;
         checkOutput($sformatf("%s rsp%0d", v.name, j), {24'h0, got}, {24'h0, v.rsp[(v.nrsp-1-j)*8 +: 8]});
      end
      checkOutput($sformatf("%s we_pulses", v.name), we_cnt - we_base, v.exp_we);
      checkOutput($sformatf("%s released_cycles", v.name), low_cnt - low_base, v.exp_low);
   endtask

   initial begin
      vec_t tmp;
      int   we_base;
      checks        = 0;
      failures      = 0;
      we_cnt        = 0;
      low_cnt       = 0;
      halt_at       = NEVER;
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 8'h00;
      bus.rsp_ready = 1'b1;

      addVec("wr_prog",   14, 112'h01000B353F146881F0203F4474F0, 0, 32'h0,      NEVER, 11, 0);
      addVec("wr_m12",     4, 32'h010C010C,                      0, 32'h0,      NEVER,  1, 0);
      addVec("rd_prog",    3, 24'h020003,                        3, 24'h353F14, NEVER,  0, 0);
      addVec("rd_m12",     3, 24'h020C01,                        1, 8'h0C,      NEVER,  0, 0);
      addVec("run_halt",   3, 24'h0300C8,                        3, 24'h000015, 20,     0, 21);
      addVec("run_tie",    3, 24'h030015,                        3, 24'h000015, 20,     0, 21);
      addVec("wr_loop",    4, 32'h0100019F,                      0, 32'h0,      NEVER,  1, 0);
      addVec("run_tmo50",  3, 24'h030032,                        3, 24'h010032, NEVER,  0, 50);
      addVec("run_t1",     3, 24'h030001,                        3, 24'h010001, NEVER,  0, 1);
      addVec("wr_wrap",    5, 40'h01FF02AA55,                    0, 32'h0,      NEVER,  2, 0);
      addVec("rd_wrap",    3, 24'h02FF02,                        2, 16'hAA55,   NEVER,  0, 0);
      addVec("bad_op",     1, 8'h7E,                             1, 8'hFF,      NEVER,  0, 0);
      addVec("run_t0",     3, 24'h030000,                        3, 24'h010000, NEVER,  0, 0);
      addVec("wr_clear",   7, 56'h01100400000000,                0, 32'h0,      NEVER,  4, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset cmd_ready", bus.cmd_ready, 0);
      checkOutput("reset rsp_valid", bus.rsp_valid, 0);
      checkOutput("reset rsp_data",  bus.rsp_data,  0);
      checkOutput("reset mem_we",    bus.mem_we,    0);
      checkOutput("reset mem_addr",  bus.mem_addr,  0);
      checkOutput("reset mem_wdata", bus.mem_wdata, 0);
      checkOutput("reset cpu_reset", bus.cpu_reset, 1);
      checkOutput("reset busy",      bus.busy,      0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (vecs[k]) applyStimulus(vecs[k]);

      // Backpressure: the first read byte must sit still while rsp_ready is low
      $display("[TB] backpressure sequence");
      rsp_q.delete();
      bus.rsp_ready = 1'b0;
      sendByte(8'h02);
      sendByte(8'hFF);
      sendByte(8'h02);
      for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput($sformatf("bp rsp_valid c%0d", c), bus.rsp_valid, 1);
         checkOutput($sformatf("bp rsp_data c%0d", c),  bus.rsp_data,  8'hAA);
         checkOutput($sformatf("bp cmd_ready c%0d", c), bus.cmd_ready, 0);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      waitIdle("bp", 200);
      checkOutput("bp rsp_count", rsp_q.size(), 2);
      if (rsp_q.size() == 2) begin
         checkOutput("bp rsp0", rsp_q[0], 8'hAA);
         checkOutput("bp rsp1", rsp_q[1], 8'h55);
      end

      // Reset right after the second data byte of a four-byte write
      $display("[TB] mid-write reset sequence");
      we_base = we_cnt;
      sendByte(8'h01);
      sendByte(8'h10);
      sendByte(8'h04);
      sendByte(8'hD1);
      sendByte(8'hD2);
      reset         = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'hD3;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst busy",      bus.busy,      0);
      checkOutput("rst cpu_reset", bus.cpu_reset, 1);
      checkOutput("rst mem_we",    bus.mem_we,    0);
      checkOutput("rst rsp_valid", bus.rsp_valid, 0);
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rst we_pulses", we_cnt - we_base, 2);
      tmp.name    = "rd_after_rst";
      tmp.ncmd    = 3;
      tmp.cmd     = 128'h021004;
      tmp.nrsp    = 4;
      tmp.rsp     = 32'hD1D20000;
      tmp.halt_at = NEVER;
      tmp.exp_we  = 0;
      tmp.exp_low = 0;
      applyStimulus(tmp);

      // Count byte of zero reads the whole 256-byte memory, wrapping back to 0
      $display("[TB] full-memory read sequence");
      rsp_q.delete();
      sendByte(8'h02);
      sendByte(8'h00);
      sendByte(8'h00);
      waitIdle("rd256", 5000);
      checkOutput("rd256 rsp_count", rsp_q.size(), 256);
      if (rsp_q.size() == 256) begin
         checkOutput("rd256 byte0",   rsp_q[0],   8'h55);
         checkOutput("rd256 byte1",   rsp_q[1],   8'h3F);
         checkOutput("rd256 byte12",  rsp_q[12],  8'h0C);
         checkOutput("rd256 byte16",  rsp_q[16],  8'hD1);
         checkOutput("rd256 byte255", rsp_q[255], 8'hAA);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the bench can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
